data_mem_ctrl: RTL

Parametrised, byte-addressable data memory for the MIPS datapath, replacing the fixed 64-word, word-only store. It handles byte, halfword and word stores and loads, with sign or zero extension on loads. Reads are registered and signalled with a valid pulse. After reset or a soft clear, a sequential sweep zeroes the array. The block sits between the pipelined CPU's MEM stage and the load/store unit.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/data_mem_ctrl_if.sv | 28 ++
 rtl/dmem_array.sv | 30 +++
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory controller:
// access-size encodings, controller state encoding and the byte-enable helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 is reserved and behaves as a word

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Byte enables for one 32-bit word, given access size and addr[1:0].
    // Half accesses look only at addr[1]; word (and reserved) ignore both bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the CPU MEM stage (master) and the data memory (slave).
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              clr;
    logic              req;
    logic              wr_en;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              busy;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output clr, req, wr_en, size, sign_ext, addr, wdata,
        input  ready, busy, rvalid, rdata, err
    );

    modport slave (
        input  clr, req, wr_en, size, sign_ext, addr, wdata,
        output ready, busy, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W single-port storage with per-byte write enables and a
// registered read port. Contents are not reset; the controller's sweep zeroes them.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    // Read register only moves on a load, so the word it holds stays put between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller for the MIPS MEM stage.
// Owns the clear sweep FSM, lane steering for stores, and extension of loads.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// acknowledged with err=1, rdata=0 and no memory effect; without it low address
// bits below the access size are simply ignored and err stays 0.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic             clk,
    input  logic             r_st,
    data_mem_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LANES = DATA_W/8;
    localparam logic [0:0] S_CLEAR = ST_CLEAR;
    localparam logic [0:0] S_RUN   = ST_RUN;

    logic [0:0]        state;
    logic [IDX_W-1:0]  cnt;
    logic              busy_q, rvalid_q, err_q, zero_q;
    logic [1:0]        lane_q, size_q;
    logic              sext_q;

    logic              acc, mis;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  arr_idx;
    logic [LANES-1:0]  arr_be;
    logic [DATA_W-1:0] arr_wd, rep_wd, rd_raw, ext;
    logic              arr_re;
    logic [7:0]        b_sel;
    logic [15:0]       h_sel;
    logic              unused_addr;

    // Upper address bits only alias the array.
    assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W+2];

    assign idx       = bus.addr[IDX_W+1:2];
    assign bus.ready = (state == S_RUN) && !bus.clr;
    assign acc       = bus.req && bus.ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    // Half must be 2-byte aligned; word and reserved must be 4-byte aligned.
    always_comb begin
        mis = 1'b0;
        if (bus.size == SZ_HALF)      mis = bus.addr[0];
        else if (bus.size != SZ_BYTE) mis = (bus.addr[1:0] != 2'b00);
    end
`else
    assign mis = 1'b0;
`endif

    // Store data is right-justified; replicate it so every candidate lane sees it.
    always_comb begin
        case (bus.size)
            SZ_BYTE: rep_wd = {LANES{bus.wdata[7:0]}};
            SZ_HALF: rep_wd = {(LANES/2){bus.wdata[15:0]}};
            default: rep_wd = bus.wdata;
        endcase
    end

    // Array port mux: the sweep owns the port in CLEAR, accepted accesses in RUN.
    always_comb begin
        arr_idx = idx;
        arr_be  = '0;
        arr_wd  = rep_wd;
        arr_re  = 1'b0;
        if (state == S_CLEAR) begin
            arr_idx = cnt;
            arr_be  = '1;
            arr_wd  = '0;
        end else if (acc && !mis) begin
            if (bus.wr_en) arr_be = lane_mask(bus.size, bus.addr[1:0]);
            else           arr_re = 1'b1;
        end
    end

    dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .rst_n (r_st),
        .idx   (arr_idx),
        .be    (arr_be),
        .wdata (arr_wd),
        .re    (arr_re),
        .rdata (rd_raw)
    );

    // Clear sweep / run FSM plus registered response flags and load steering info.
    always_ff @(posedge clk or negedge r_st) begin
        if (!r_st) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            busy_q   <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            lane_q   <= 2'b00;
            size_q   <= SZ_WORD;
            sext_q   <= 1'b0;
        end else begin
            rvalid_q <= acc;
            err_q    <= acc && mis;
            if (state == S_CLEAR) begin
                if (cnt == IDX_W'(DEPTH-1)) begin
                    state  <= S_RUN;
                    busy_q <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (bus.clr) begin
                state  <= S_CLEAR;
                cnt    <= '0;
                busy_q <= 1'b1;
            end
            if (acc) begin
                if (mis) begin
                    zero_q <= 1'b1;
                end else if (!bus.wr_en) begin
                    zero_q <= 1'b0;
                    lane_q <= bus.addr[1:0];
                    size_q <= bus.size;
                    sext_q <= bus.sign_ext;
                end
            end
        end
    end

    // Shift the selected lane(s) of the read word down to bit 0 and extend.
    always_comb begin
        b_sel = rd_raw[{lane_q, 3'b000} +: 8];
        h_sel = lane_q[1] ? rd_raw[31:16] : rd_raw[15:0];
        case (size_q)
            SZ_BYTE: ext = {{(DATA_W-8){sext_q & b_sel[7]}}, b_sel};
            SZ_HALF: ext = {{(DATA_W-16){sext_q & h_sel[15]}}, h_sel};
            default: ext = rd_raw;
        endcase
    end

    assign bus.rdata  = zero_q ? '0 : ext;
    assign bus.busy   = busy_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
endmodule
